sm_clk_ctrl: RTL and testbench

//  Parametrised clock-control unit replacing the fixed power-of-two divider at top level.

---
 rtl/sm_clk_ctrl.sv | 116 +++++++++++
 tb/tb_sm_clk_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sm_clk_ctrl.sv
// sm_clk_ctrl: programmable glitch-free clock divider with stop/run/single-step/burst modes
// and a debounced step button; clkEn strobes with every clkOut rising edge.
module sm_clk_ctrl #(
  parameter int CNT_W   = 32,
  parameter int SHIFT   = 16,
  parameter int DIV_W   = 4,
  parameter int DEB_LEN = 8,
  parameter int BURST_W = 8
) (
  input  logic               clkIn,
  input  logic               rst,
  input  logic [DIV_W-1:0]   devide,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic               stepBtn,
  input  logic [BURST_W-1:0] burstLen,
  output logic               clkOut,
  output logic               clkEn,
  output logic               busy,
  output logic [31:0]        tickCnt
);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2, S_BURST = 2'd3;
  localparam logic [1:0] M_RUN = 2'd1, M_STEP = 2'd2, M_BURST = 2'd3;
  localparam logic [31:0] DMAX = 32'(CNT_W - SHIFT - 1);
  localparam int DW = $clog2(DEB_LEN + 1);

  logic [CNT_W-1:0]   cntr_q, cntr_d, mask, mask_n, low;
  logic [DIV_W-1:0]   div_q, div_n;
  logic [1:0]         st_q, st_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic [31:0]        tick_q;
  logic               clk_q, en_q, pend_q;
  logic               s1_q, s2_q, lvl_q, edge_q;
  logic [DW-1:0]      dcnt_q;
  logic               bnd, half, issue, ev, acc;

  assign div_n  = (32'(devide) > DMAX) ? DIV_W'(DMAX) : devide;
  assign mask   = ~({CNT_W{1'b1}} << (SHIFT + 32'(div_q)));
  assign mask_n = ~({CNT_W{1'b1}} << (SHIFT + 32'(div_n)));
  assign low    = cntr_q & mask;
  assign bnd    = enable && (low == mask);
  assign half   = low == (mask >> 1);
  // Realign at a boundary so a larger ratio always starts with a full period
  assign cntr_d = bnd ? ((cntr_q + 1'b1) & ~mask_n) : cntr_q + 1'b1;
  assign ev     = edge_q | pend_q;
  assign acc    = (s2_q != lvl_q) && (dcnt_q == DW'(DEB_LEN - 1));

  always_comb begin
    st_d  = st_q;
    rem_d = rem_q;
    issue = 1'b0;
    if (enable)
      case (st_q)
        S_IDLE: begin
          if (mode == M_RUN) st_d = S_RUN;
          else if (mode == M_STEP && ev) st_d = S_STEP;
          else if (mode == M_BURST && ev && burstLen != '0) begin
            st_d  = S_BURST;
            rem_d = burstLen;
          end
        end
        S_RUN: begin
          issue = bnd && mode == M_RUN;
          st_d  = (bnd && mode != M_RUN) ? S_IDLE : S_RUN;
        end
        S_STEP: begin
          issue = bnd && mode == M_STEP;
          st_d  = (mode != M_STEP || bnd) ? S_IDLE : S_STEP;
        end
        default: begin
          issue = bnd && mode == M_BURST;
          rem_d = (mode != M_BURST) ? '0 : issue ? rem_q - 1'b1 : rem_q;
          st_d  = (mode != M_BURST || (issue && rem_q == 1)) ? S_IDLE : S_BURST;
        end
      endcase
  end

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      cntr_q <= '0;
      div_q  <= '0;
      st_q   <= S_IDLE;
      rem_q  <= '0;
      tick_q <= '0;
      clk_q  <= 1'b0;
      en_q   <= 1'b0;
      pend_q <= 1'b0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      lvl_q  <= 1'b0;
      edge_q <= 1'b0;
      dcnt_q <= '0;
    end else begin
      s1_q   <= stepBtn;
      s2_q   <= s1_q;
      dcnt_q <= (s2_q == lvl_q || acc) ? '0 : dcnt_q + 1'b1;
      lvl_q  <= acc ? s2_q : lvl_q;
      edge_q <= acc && s2_q;
      pend_q <= enable ? 1'b0 : (pend_q | edge_q);
      en_q   <= issue;
      if (enable) begin
        cntr_q <= cntr_d;
        div_q  <= bnd ? div_n : div_q;
        st_q   <= st_d;
        rem_q  <= rem_d;
        tick_q <= tick_q + 32'(issue);
        clk_q  <= issue ? 1'b1 : half ? 1'b0 : clk_q;
      end
    end
  end

  assign clkOut  = clk_q;
  assign clkEn   = en_q && enable;
  assign busy    = (st_q == S_STEP) || (st_q == S_BURST);
  assign tickCnt = tick_q;
endmodule

// File: tb/tb_sm_clk_ctrl.sv
// tb_sm_clk_ctrl: directed bench; expected tick counts are queued when a pulse is requested
// and popped by a monitor on every clkEn strobe.
module tb_sm_clk_ctrl;
  logic       clk = 1'b0, rst = 1'b1, enable = 1'b1, stepBtn = 1'b0;
  logic [3:0] devide = 4'd1;
  logic [1:0] mode = 2'd0;
  logic [7:0] burstLen = 8'd0;
  logic       clkOut, clkEn, busy;
  logic [31:0] tickCnt;
  logic [31:0] exp_q[$];
  int tests = 0, fails = 0, n_en = 0, cyc = 0, t0 = 0;
  bit busy_seen = 0, en_seen = 0;

  sm_clk_ctrl #(.CNT_W(32), .SHIFT(2), .DIV_W(4), .DEB_LEN(4), .BURST_W(8)) dut (
    .clkIn(clk), .rst(rst), .devide(devide), .enable(enable), .mode(mode),
    .stepBtn(stepBtn), .burstLen(burstLen), .clkOut(clkOut), .clkEn(clkEn),
    .busy(busy), .tickCnt(tickCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic wait_n(input int target, input int bound);
    for (int i = 0; i < bound && n_en < target; i++) step(1);
    chk("strobe_timeout", 32'(n_en >= target), 32'd1);
  endtask

  task automatic push_range(input int a, input int b);
    for (int i = a; i <= b; i++) exp_q.push_back(32'(i));
  endtask

  always @(negedge clk) begin
    if (busy) busy_seen = 1;
    if (clkEn) begin
      n_en++;
      en_seen = 1;
      chk("unexpected_strobe", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("tick_at_strobe", tickCnt, exp_q.pop_front());
      chk("clkout_at_strobe", 32'(clkOut), 32'd1);
    end
  end

  initial begin
    step(2);
    chk("rst_clkout", 32'(clkOut), 0);
    chk("rst_clken", 32'(clkEn), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tick", tickCnt, 0);
    rst = 1'b0;
    step(10);
    // 1: free run, divide by 8
    mode = 2'd1;
    push_range(1, 10);
    wait_n(1, 30);
    t0 = cyc;
    step(3);
    chk("run8_high", 32'(clkOut), 1);
    step(1);
    chk("run8_low", 32'(clkOut), 0);
    wait_n(2, 20);
    chk("run8_period", 32'(cyc - t0), 8);
    wait_n(10, 100);
    chk("run8_tick10", tickCnt, 10);
    mode = 2'd0;
    step(12);
    chk("stop_no_extra", 32'(n_en), 10);
    // 2: ratio change mid-period
    mode = 2'd1;
    push_range(11, 14);
    wait_n(11, 30);
    t0 = cyc;
    step(3);
    devide = 4'd0;
    wait_n(12, 20);
    chk("div_old_period", 32'(cyc - t0), 8);
    t0 = cyc;
    wait_n(13, 20);
    chk("div_new_period", 32'(cyc - t0), 4);
    step(1);
    chk("div4_high", 32'(clkOut), 1);
    step(1);
    chk("div4_low", 32'(clkOut), 0);
    wait_n(14, 20);
    mode = 2'd0;
    step(12);
    chk("run_stop_count", 32'(n_en), 14);
    // 3: single step through a bouncing button, then a short glitch
    mode = 2'd2;
    push_range(15, 15);
    busy_seen = 0;
    stepBtn = 1'b1; step(1);
    stepBtn = 1'b0; step(1);
    stepBtn = 1'b1; step(7);
    stepBtn = 1'b0;
    wait_n(15, 30);
    chk("step_busy_seen", 32'(busy_seen), 1);
    chk("step_busy_after", 32'(busy), 0);
    chk("step_tick", tickCnt, 15);
    step(10);
    busy_seen = 0;
    stepBtn = 1'b1; step(2);
    stepBtn = 1'b0; step(20);
    chk("glitch_busy", 32'(busy_seen), 0);
    chk("glitch_count", 32'(n_en), 15);
    // 4: burst of five, then an empty burst
    mode = 2'd3;
    burstLen = 8'd5;
    push_range(16, 20);
    stepBtn = 1'b1;
    wait_n(19, 80);
    chk("burst_busy_4th", 32'(busy), 1);
    wait_n(20, 20);
    chk("burst_busy_5th", 32'(busy), 0);
    stepBtn = 1'b0;
    step(20);
    chk("burst_count", 32'(n_en), 20);
    burstLen = 8'd0;
    busy_seen = 0;
    stepBtn = 1'b1; step(8);
    stepBtn = 1'b0; step(20);
    chk("burst0_busy", 32'(busy_seen), 0);
    chk("burst0_count", 32'(n_en), 20);
    // 5: abort a long burst after three pulses
    burstLen = 8'd200;
    push_range(21, 23);
    stepBtn = 1'b1;
    wait_n(23, 80);
    mode = 2'd0;
    stepBtn = 1'b0;
    step(1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_clk_high", 32'(clkOut), 1);
    step(1);
    chk("abort_clk_fall", 32'(clkOut), 0);
    step(20);
    chk("abort_count", 32'(n_en), 23);
    chk("abort_tick", tickCnt, 23);
    // 6: freeze mid-run, then reset mid-burst
    devide = 4'd1;
    step(10);
    mode = 2'd1;
    push_range(24, 25);
    wait_n(24, 30);
    t0 = cyc;
    step(2);
    enable = 1'b0;
    en_seen = 0;
    step(20);
    chk("freeze_no_en", 32'(en_seen), 0);
    chk("freeze_tick", tickCnt, 24);
    chk("freeze_clk", 32'(clkOut), 1);
    enable = 1'b1;
    wait_n(25, 20);
    chk("freeze_phase", 32'(cyc - t0), 28);
    mode = 2'd0;
    step(12);
    mode = 2'd3;
    burstLen = 8'd200;
    push_range(26, 27);
    stepBtn = 1'b1;
    wait_n(27, 100);
    stepBtn = 1'b0;
    step(2);
    rst = 1'b1;
    #1;
    chk("rst_mid_clkout", 32'(clkOut), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_tick", tickCnt, 0);
    step(1);
    rst = 1'b0;
    step(20);
    chk("post_rst_tick", tickCnt, 0);
    chk("post_rst_count", 32'(n_en), 27);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
